// File: rtl/phase_uart_pkg.sv
// rtl/phase_uart_pkg.sv - shared state type, frame constants and byte helpers for the phase-tag UART
package phase_uart_pkg;

  typedef enum logic [2:0] {IDLE, READ, LATCH, SEND, DONE} state_t;

  localparam int FRAME_BYTES = 4;
  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

  function automatic logic [7:0] tag_checksum(input logic [15:0] tag);
    return tag[15:8] ^ tag[7:0];
  endfunction

  function automatic logic [7:0] frame_byte(input logic [7:0] sync, input logic [15:0] tag,
                                            input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = sync;
      2'd1:    b = tag[15:8];
      2'd2:    b = tag[7:0];
      default: b = tag_checksum(tag);
    endcase
    return b;
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// rtl/uart_tx_byte.sv - 8N1 byte serialiser with registered tx and an end-of-stop done pulse
module uart_tx_byte #(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       done
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] BAUD_PRE  = CW'(CLKS_PER_BIT - 2);
  localparam logic [3:0]    STOP_BIT  = 4'd9;

  logic          active;
  logic [CW-1:0] baud_cnt;
  logic [3:0]    bit_idx;
  logic [8:0]    shift;

  // start wins over the final stop cycle so consecutive bytes abut with no idle gap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active   <= 1'b0;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      tx       <= 1'b1;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        active   <= 1'b1;
        baud_cnt <= '0;
        bit_idx  <= '0;
        shift    <= {1'b1, data};
        tx       <= 1'b0;
      end else if (active) begin
        if (baud_cnt == BAUD_LAST) begin
          baud_cnt <= '0;
          if (bit_idx == STOP_BIT) begin
            active <= 1'b0;
            tx     <= 1'b1;
          end else begin
            bit_idx <= bit_idx + 4'd1;
            tx      <= shift[0];
            shift   <= {1'b1, shift[8:1]};
          end
        end else begin
          baud_cnt <= baud_cnt + CW'(1);
        end
        if (bit_idx == STOP_BIT && baud_cnt == BAUD_PRE) done <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/phase_tag_uart_tx.sv
// rtl/phase_tag_uart_tx.sv - pops 16-bit phase tags from a FIFO and sends each as a 4-byte UART frame
module phase_tag_uart_tx
  import phase_uart_pkg::*;
#(
  parameter int         CLKS_PER_BIT = 104,
  parameter logic [7:0] SYNC_BYTE    = DEFAULT_SYNC_BYTE
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tx_enable,
  input  logic        fifo_empty,
  input  logic [15:0] fifo_data,
  output logic        fifo_rd_en,
  output logic        tx,
  output logic        busy,
  output logic [15:0] frames_sent
);

  localparam logic [1:0] LAST_BYTE = 2'(FRAME_BYTES - 1);

  state_t      state, state_next;
  logic [15:0] tag;
  logic [1:0]  byte_idx;
  logic        byte_start;
  logic        byte_done;
  logic [7:0]  byte_data;

  always_comb begin
    state_next = state;
    byte_start = 1'b0;
    byte_data  = SYNC_BYTE;
    case (state)
      IDLE:  if (tx_enable && !fifo_empty) state_next = READ;
      READ:  state_next = LATCH;
      // the sync byte does not depend on the tag, so it can launch while the tag is captured
      LATCH: begin
        state_next = SEND;
        byte_start = 1'b1;
      end
      SEND: begin
        if (byte_done) begin
          if (byte_idx == LAST_BYTE) begin
            state_next = DONE;
          end else begin
            byte_start = 1'b1;
            byte_data  = frame_byte(SYNC_BYTE, tag, byte_idx + 2'd1);
          end
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      fifo_rd_en  <= 1'b0;
      busy        <= 1'b0;
      frames_sent <= '0;
      tag         <= '0;
      byte_idx    <= '0;
    end else begin
      state      <= state_next;
      fifo_rd_en <= (state_next == READ);
      busy       <= (state_next != IDLE);
      if (state == LATCH) begin
        tag      <= fifo_data;
        byte_idx <= '0;
      end
      if (state == SEND && byte_done && byte_idx != LAST_BYTE) byte_idx <= byte_idx + 2'd1;
      if (state == DONE) frames_sent <= frames_sent + 16'd1;
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte (
    .clk   (clk),
    .rst_n (rst_n),
    .start (byte_start),
    .data  (byte_data),
    .tx    (tx),
    .done  (byte_done)
  );

endmodule

// File: tb/tb_phase_tag_uart_tx.sv
// tb/tb_phase_tag_uart_tx.sv - scoreboard bench: FIFO model feeds expected frames, UART monitor decodes tx
`timescale 1ns/1ps
module tb_phase_tag_uart_tx;

  localparam int         CPB  = 4;
  localparam logic [7:0] SYNC = 8'hA5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tx_enable = 1'b0;
  logic        fifo_empty;
  logic [15:0] fifo_data;
  logic        fifo_rd_en;
  logic        tx;
  logic        busy;
  logic [15:0] frames_sent;

  phase_tag_uart_tx #(
    .CLKS_PER_BIT(CPB),
    .SYNC_BYTE   (SYNC)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tx_enable  (tx_enable),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_rd_en (fifo_rd_en),
    .tx         (tx),
    .busy       (busy),
    .frames_sent(frames_sent)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [15:0] fifo_q[$];
  logic [7:0]  exp_bytes[$];
  logic [15:0] exp_count = 16'd0;
  int          rd_count = 0;
  int          last_rd_cyc = 0;
  int          last_end_cyc = 0;
  int          frame_start_cyc = 0;
  int          start_gap = 0;
  int          rd_gap = 0;
  int          frames_seen = 0;
  int          mon_pos = 0;
  int          mon_bit = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // FIFO model: pops on rd_en, presents data, and queues the frame the host should see
  initial begin : fifo_model
    logic [15:0] t;
    int garble;
    garble = 0;
    fifo_empty = 1'b1;
    fifo_data = 16'h0000;
    forever begin
      @(posedge clk);
      #1;
      if (garble > 0) begin
        garble--;
        if (garble == 0) fifo_data = 16'($urandom);
      end
      if (fifo_rd_en === 1'b1) begin
        rd_count++;
        last_rd_cyc = cyc;
        chk("rd_while_empty", fifo_empty, 0);
        if (fifo_q.size() != 0) begin
          t = fifo_q.pop_front();
          fifo_data = t;
          garble = 2;
          exp_bytes.push_back(SYNC);
          exp_bytes.push_back(t[15:8]);
          exp_bytes.push_back(t[7:0]);
          exp_bytes.push_back(t[15:8] ^ t[7:0]);
        end
      end
      fifo_empty = (fifo_q.size() == 0);
    end
  end

  // UART monitor: every tx cycle must hold the expected level for the whole bit
  initial begin : monitor
    logic [7:0] eb;
    logic [7:0] got;
    logic       lvl;
    int         bad;
    bit         aborted;
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1) begin
        mon_pos = 0;
        continue;
      end
      if (mon_pos != 0) chk("byte_gap", tx, 0);
      if (tx !== 1'b0) begin
        mon_pos = 0;
        continue;
      end
      if (mon_pos == 0) begin
        start_gap = cyc - last_end_cyc;
        rd_gap = last_rd_cyc - last_end_cyc;
        frame_start_cyc = cyc;
        chk("start_latency", cyc - last_rd_cyc, 2);
      end
      chk("byte_expected", exp_bytes.size() != 0, 1);
      eb = (exp_bytes.size() != 0) ? exp_bytes.pop_front() : 8'h00;
      got = 8'h00;
      bad = 0;
      aborted = 1'b0;
      for (int b = 0; b < 10 && !aborted; b++) begin
        for (int k = 0; k < CPB && !aborted; k++) begin
          if (b != 0 || k != 0) @(negedge clk);
          if (rst_n !== 1'b1) begin
            aborted = 1'b1;
          end else begin
            mon_bit = b;
            lvl = (b == 0) ? 1'b0 : ((b == 9) ? 1'b1 : eb[b-1]);
            if (tx !== lvl || busy !== 1'b1) bad++;
            if (b >= 1 && b <= 8 && k == CPB / 2) got[b-1] = tx;
          end
        end
      end
      if (aborted) begin
        mon_pos = 0;
        mon_bit = 0;
        continue;
      end
      chk("byte_value", got, eb);
      chk("bit_timing", bad, 0);
      mon_pos++;
      mon_bit = 0;
      if (mon_pos == 4) begin
        mon_pos = 0;
        last_end_cyc = cyc;
        exp_count = exp_count + 16'd1;
        frames_seen++;
        @(negedge clk);
        chk("busy_in_done", busy, 1);
        @(negedge clk);
        chk("busy_in_idle", busy, 0);
        chk("frames_sent", frames_sent, exp_count);
      end
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_frames(input int target, input int budget);
    int n;
    n = 0;
    while (frames_seen < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("frame_timeout", frames_seen >= target, 1);
    wait_cycles(3);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int base;
    int tgt;
    int n;
    int viol;

    wait_cycles(4);
    chk("rst_tx", tx, 1);
    chk("rst_rd_en", fifo_rd_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frames", frames_sent, 0);
    rst_n = 1'b1;
    wait_cycles(2);

    // single tag
    base = rd_count;
    fifo_q.push_back(16'h1234);
    tx_enable = 1'b1;
    wait_frames(frames_seen + 1, 400);
    chk("t1_rd_pulses", rd_count - base, 1);
    chk("t1_frames", frames_sent, 1);
    chk("t1_frame_len", last_end_cyc - frame_start_cyc + 1, 40 * CPB);

    // two queued tags, back to back
    base = rd_count;
    fifo_q.push_back(16'hFFFF);
    fifo_q.push_back(16'h0001);
    wait_frames(frames_seen + 2, 800);
    chk("t2_rd_pulses", rd_count - base, 2);
    chk("t2_start_gap", start_gap, 5);
    chk("t2_rd_gap", rd_gap, 3);
    chk("t2_frames", frames_sent, 3);

    // empty FIFO with enable high
    viol = 0;
    repeat (500) begin
      @(negedge clk);
      if (fifo_rd_en !== 1'b0 || tx !== 1'b1 || busy !== 1'b0) viol++;
    end
    chk("t3_empty_idle", viol, 0);

    // enable dropped during byte 1
    base = rd_count;
    tgt = frames_seen + 1;
    fifo_q.push_back(16'($urandom));
    fifo_q.push_back(16'($urandom));
    n = 0;
    while (mon_pos != 1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("t4_reach_byte1", mon_pos, 1);
    tx_enable = 1'b0;
    wait_frames(tgt, 400);
    wait_cycles(200);
    chk("t4_rd_hold", rd_count - base, 1);
    chk("t4_fifo_left", fifo_q.size(), 1);
    chk("t4_busy_low", busy, 0);
    tx_enable = 1'b1;
    wait_frames(tgt + 1, 400);
    chk("t4_rd_resume", rd_count - base, 2);

    // reset during byte 2
    fifo_q.push_back(16'h5A3C);
    n = 0;
    while (!(mon_pos == 2 && mon_bit >= 3) && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("t5_reach_byte2", mon_pos == 2, 1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("t5_async_tx", tx, 1);
    chk("t5_async_busy", busy, 0);
    chk("t5_async_frames", frames_sent, 0);
    exp_bytes.delete();
    exp_count = 16'd0;
    wait_cycles(3);
    rst_n = 1'b1;
    wait_cycles(2);
    fifo_q.push_back(16'hABCD);
    wait_frames(frames_seen + 1, 400);
    chk("t5_frames_after", frames_sent, 1);

    // frames_sent wrap
    @(negedge clk);
    force dut.frames_sent = 16'hFFFF;
    exp_count = 16'hFFFF;
    @(negedge clk);
    release dut.frames_sent;
    @(negedge clk);
    chk("t6_preset", frames_sent, 16'hFFFF);
    fifo_q.push_back(16'($urandom));
    wait_frames(frames_seen + 1, 400);
    chk("t6_wrap", frames_sent, 0);

    // randomized tags, gaps and enable toggles
    tgt = frames_seen + 10;
    for (int i = 0; i < 10; i++) begin
      wait_cycles($urandom_range(0, 80));
      fifo_q.push_back(16'($urandom));
      if ($urandom_range(0, 3) == 0) tx_enable = ~tx_enable;
    end
    tx_enable = 1'b1;
    wait_frames(tgt, 4000);
    chk("rand_fifo_drained", fifo_q.size(), 0);
    chk("rand_no_leftover", exp_bytes.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
